// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU/FIFO command port among NREQ requesters, tagging results by issuer.
// Optional macro ARB_PRIO_EN: requester 0 gets strict priority, the rest round-robin among 1..NREQ-1.
module alu_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int TAG_DEPTH = 8,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ*10-1:0] req_data,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  output logic [9:0]        alu_data,
  output logic              alu_valid,
  input  logic              alu_ready,
  input  logic              alu_res_valid,
  input  logic [8:0]        alu_res,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [8:0]        rsp_result,
  output logic              err_underflow
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(TAG_DEPTH);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic           any_valid;
  logic [IDW-1:0] cand;
  int             idx;

  logic [IDW-1:0] tag_mem [TAG_DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [CW-1:0]  count;

  logic           pop_avail;
  logic           can_load;
  logic           push;
  logic           pop_ok;
  logic [IDW-1:0] pop_tag;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
`ifdef ARB_PRIO_EN
    if (req_valid[0]) begin
      any_valid = 1'b1;
    end else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx > NREQ - 1) idx = idx - (NREQ - 1);
        cand = IDW'(idx);
        if (!any_valid && req_valid[cand]) begin
          any_valid = 1'b1;
          winner    = cand;
        end
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
`endif
  end

  // Handshake: a transfer happens on an edge where valid and ready are both 1.
  // The full check is bypassed when a result pops a tag in the same cycle.
  always_comb begin
    pop_avail = alu_res_valid && (count != '0);
    can_load  = reset && (!alu_valid || alu_ready) && ((count != FULL) || pop_avail);
    push      = can_load && any_valid;
    req_ready = push ? (NREQ'(1) << winner) : '0;
    pop_ok    = alu_res_valid && ((count != '0) || push);
    pop_tag   = (count != '0) ? tag_mem[rd_ptr] : winner;
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= winner;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_valid     <= 1'b0;
      alu_data      <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      err_underflow <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
`ifdef ARB_PRIO_EN
      rr_ptr        <= IDW'(1);
`else
      rr_ptr        <= '0;
`endif
    end else begin
      if (push) begin
        alu_valid <= 1'b1;
        alu_data  <= req_data[winner*10 +: 10];
      end else if (alu_ready) begin
        alu_valid <= 1'b0;
      end

`ifdef ARB_PRIO_EN
      if (push && winner != '0)
        rr_ptr <= (winner == IDW'(NREQ - 1)) ? IDW'(1) : winner + IDW'(1);
`else
      if (push)
        rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
`endif

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop_ok) count <= count + CW'(1);
      else if (!push && pop_ok) count <= count - CW'(1);

      rsp_valid <= pop_ok;
      if (pop_ok) begin
        rsp_id     <= pop_tag;
        rsp_result <= alu_res;
      end
      if (alu_res_valid && !pop_ok) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: randomized and directed traffic against a queue-based reference model.
module tb_alu_rr_arbiter;
  localparam int NREQ = 4;
  localparam int TAG_DEPTH = 8;
  localparam int IDW = 2;

  logic              clk;
  logic              reset;
  logic [NREQ*10-1:0] req_data;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [9:0]        alu_data;
  logic              alu_valid;
  logic              alu_ready;
  logic              alu_res_valid;
  logic [8:0]        alu_res;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [8:0]        rsp_result;
  logic              err_underflow;

  alu_rr_arbiter #(.NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .alu_data(alu_data), .alu_valid(alu_valid),
    .alu_ready(alu_ready), .alu_res_valid(alu_res_valid), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .err_underflow(err_underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int               m_ptr;
  logic [9:0]       m_cmd_q[$];
  int               m_tags[$];
  logic             m_err = 1'b0;
  logic [IDW+8:0]   exp_q[$];
  bit               started = 1'b0;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int reset_ptr();
`ifdef ARB_PRIO_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    int i;
`ifdef ARB_PRIO_EN
    if (v[0]) return 0;
    for (int k = 0; k < NREQ - 1; k++) begin
      i = 1 + ((ptr - 1 + k) % (NREQ - 1));
      if (v[i]) return i;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      i = (ptr + k) % NREQ;
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic int next_ptr(input int w, input int ptr);
`ifdef ARB_PRIO_EN
    if (w == 0) return ptr;
    return 1 + (w % (NREQ - 1));
`else
    return (w + 1) % NREQ;
`endif
  endfunction

  function automatic logic [NREQ*10-1:0] rand_data();
    logic [NREQ*10-1:0] d;
    for (int i = 0; i < NREQ; i++) d[i*10 +: 10] = 10'($urandom);
    return d;
  endfunction

  // driver: one clock cycle of stimulus, request-side checks, and model update
  task automatic cycle(input logic rst_n, input logic [NREQ-1:0] rv, input logic [NREQ*10-1:0] rd,
                       input logic ar, input logic resv, input logic [8:0] res);
    logic busy, drain, pop_avail, can_load, had;
    logic [NREQ-1:0] exp_ready;
    int w, popped;
    reset = rst_n; req_valid = rv; req_data = rd;
    alu_ready = ar; alu_res_valid = resv; alu_res = res;
    #1;
    busy      = m_cmd_q.size() != 0;
    drain     = busy && ar;
    pop_avail = resv && (m_tags.size() > 0);
    can_load  = rst_n && (!busy || ar) && ((m_tags.size() < TAG_DEPTH) || pop_avail);
    w         = pick(rv, m_ptr);
    exp_ready = (can_load && w >= 0) ? (NREQ'(1) << w) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (started) check("alu_valid", 32'(alu_valid), 32'(busy));
    if (drain) check("alu_data", 32'(alu_data), 32'(m_cmd_q[0]));
    @(posedge clk);
    if (!rst_n) begin
      m_cmd_q.delete(); m_tags.delete(); exp_q.delete();
      m_ptr = reset_ptr(); m_err = 1'b0;
      #1;
      check("rst_alu_valid", 32'(alu_valid), 32'd0);
      check("rst_alu_data", 32'(alu_data), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_result", 32'(rsp_result), 32'd0);
      check("rst_err_underflow", 32'(err_underflow), 32'd0);
      #1;
    end else begin
      if (drain) void'(m_cmd_q.pop_front());
      had = m_tags.size() > 0;
      if (resv && had) begin
        popped = m_tags.pop_front();
        exp_q.push_back({IDW'(popped), res});
      end
      if (can_load && w >= 0) begin
        m_cmd_q.push_back(rd[w*10 +: 10]);
        m_tags.push_back(w);
        m_ptr = next_ptr(w, m_ptr);
      end
      if (resv && !had) begin
        if (can_load && w >= 0) begin
          popped = m_tags.pop_front();
          exp_q.push_back({IDW'(popped), res});
        end else begin
          m_err = 1'b1;
        end
      end
      #2;
    end
  endtask

  // monitor / scoreboard on the response side
  always @(posedge clk) begin
    logic [IDW+8:0] e;
    #1;
    if (started) begin
      check("err_underflow", 32'(err_underflow), 32'(m_err));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got id %0d result %0h, expected no response", rsp_id, rsp_result);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e[IDW+8:9]));
          check("rsp_result", 32'(rsp_result), 32'(e[8:0]));
        end
      end else if (exp_q.size() != 0) begin
        checks++; errors++;
        $display("FAIL rsp_missing: got rsp_valid 0, expected 1 with result %0h", exp_q[0][8:0]);
        exp_q.delete();
      end
    end
  end

  initial begin
    logic [NREQ*10-1:0] d;
    int guard;
    reset = 1'b0; req_valid = '0; req_data = '0;
    alu_ready = 1'b0; alu_res_valid = 1'b0; alu_res = '0;
    m_ptr = reset_ptr();
    @(posedge clk); #2;
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0);
    started = 1'b1;
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0);

    // underflow right after reset, then clear it
    cycle(1'b1, '0, '0, 1'b1, 1'b1, 9'h0aa);
    cycle(1'b1, '0, '0, 1'b1, 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0);

    // single requester
    d = '0; d[29:20] = 10'h151;
    cycle(1'b1, 4'b0100, d, 1'b1, 1'b0, '0);
    cycle(1'b1, '0, d, 1'b1, 1'b0, '0);
    cycle(1'b1, '0, d, 1'b1, 1'b1, 9'h005);
    cycle(1'b1, '0, d, 1'b1, 1'b0, '0);

    // fairness: eight back-to-back grants fill the tag FIFO
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'hf, rand_data(), 1'b1, 1'b0, '0);
    // full, then pop-side bypass
    cycle(1'b1, 4'hf, rand_data(), 1'b1, 1'b0, '0);
    cycle(1'b1, 4'hf, rand_data(), 1'b1, 1'b1, 9'($urandom));
    for (int i = 0; i < 8; i++) cycle(1'b1, '0, '0, 1'b1, 1'b1, 9'($urandom));

    // backpressure
    d = '0; d[19:10] = 10'h232;
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'b0010, d, 1'b0, 1'b0, '0);
    cycle(1'b1, 4'b0010, d, 1'b1, 1'b0, '0);
    cycle(1'b1, '0, d, 1'b1, 1'b0, '0);
    guard = 0;
    while (m_tags.size() > 0 && guard < 20) begin
      cycle(1'b1, '0, '0, 1'b1, 1'b1, 9'($urandom));
      guard++;
    end

    // priority pattern: req 0 and req 3 both valid, then req 0 drops
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'b1001, rand_data(), 1'b1, 1'b0, '0);
    cycle(1'b1, 4'b1000, rand_data(), 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) cycle(1'b1, '0, '0, 1'b1, 1'b1, 9'($urandom));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'b1, NREQ'($urandom_range(0, 15)), rand_data(), $urandom_range(0, 3) != 0,
            (m_tags.size() > 0) && ($urandom_range(0, 2) != 0), 9'($urandom));
    end
    guard = 0;
    while (m_tags.size() > 0 && guard < 20) begin
      cycle(1'b1, '0, '0, 1'b1, 1'b1, 9'($urandom));
      guard++;
    end

    // reset with three commands in flight, then stray results
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0001, rand_data(), 1'b1, 1'b0, '0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b1, '0, '0, 1'b1, 1'b1, 9'($urandom));
    cycle(1'b1, '0, '0, 1'b1, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
